// File: rtl/gate_response_checker.sv
// Response checker for a 2-input gate under test: synchronizes a/b/y, waits for the
// inputs to settle, compares y against the selected truth table and accumulates results.
module gate_response_checker #(
   parameter int CNT_W       = 16,
   parameter int SETTLE      = 2,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [2:0]       gate_sel,
   input  logic [CNT_W-1:0] num_samples,
   input  logic             a,
   input  logic             b,
   input  logic             y,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic             cfg_err,
   output logic [CNT_W-1:0] sample_count,
   output logic [CNT_W-1:0] err_count,
   output logic             first_err_valid,
   output logic [2:0]       first_err_vec,
   output logic [2:0]       dbg_state
);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_SETTLE   = 3'd1,
      S_COMPARE  = 3'd2,
      S_WAIT_CHG = 3'd3,
      S_DONE     = 3'd4
   } state_t;

   localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

   state_t                 r_state, w_next_state;
   logic [SYNC_STAGES-1:0] r_sync_a, r_sync_b, r_sync_y;
   logic [2:0]             r_gate_sel_q;
   logic [CNT_W-1:0]       r_num_q;
   logic [1:0]             r_prev_ab;
   logic [3:0]             r_settle_cnt;
   logic                   r_busy, r_done, r_pass, r_cfg_err, r_first_err_valid;
   logic [CNT_W-1:0]       r_sample_count, r_err_count;
   logic [2:0]             r_first_err_vec;

   logic                   w_as, w_bs, w_ys, w_expected, w_chg, w_accept, w_cfg_bad;
   logic [1:0]             w_ab;
   logic [CNT_W-1:0]       w_sample_next;

   assign w_as          = r_sync_a[SYNC_STAGES-1];
   assign w_bs          = r_sync_b[SYNC_STAGES-1];
   assign w_ys          = r_sync_y[SYNC_STAGES-1];
   assign w_ab          = {w_as, w_bs};
   assign w_chg         = (w_ab != r_prev_ab);
   assign w_accept      = start && (r_state == S_IDLE || r_state == S_DONE);
   assign w_cfg_bad     = (gate_sel >= 3'd6);
   assign w_sample_next = r_sample_count + CNT_W'(1);

   always_comb begin
      w_expected = 1'b0;
      case (r_gate_sel_q)
         3'd0:    w_expected = w_as & w_bs;
         3'd1:    w_expected = w_as | w_bs;
         3'd2:    w_expected = ~(w_as & w_bs);
         3'd3:    w_expected = ~(w_as | w_bs);
         3'd4:    w_expected = w_as ^ w_bs;
         3'd5:    w_expected = ~(w_as ^ w_bs);
         default: w_expected = 1'b0;
      endcase
   end

   // a, b, y are asynchronous to clk; only the last stage is ever used.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync_a <= '0;
         r_sync_b <= '0;
         r_sync_y <= '0;
      end else begin
         r_sync_a <= {r_sync_a[SYNC_STAGES-2:0], a};
         r_sync_b <= {r_sync_b[SYNC_STAGES-2:0], b};
         r_sync_y <= {r_sync_y[SYNC_STAGES-2:0], y};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE, S_DONE: begin
            if (start) begin
               if (w_cfg_bad)                w_next_state = S_DONE;
               else if (num_samples == '0)   w_next_state = S_DONE;
               else                          w_next_state = S_SETTLE;
            end
         end
         S_SETTLE:   if (!w_chg && r_settle_cnt == SETTLE_LAST) w_next_state = S_COMPARE;
         S_COMPARE:  w_next_state = (w_sample_next == r_num_q) ? S_DONE : S_WAIT_CHG;
         S_WAIT_CHG: if (w_chg) w_next_state = S_SETTLE;
         default:    w_next_state = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_gate_sel_q      <= '0;
         r_num_q           <= '0;
         r_prev_ab         <= '0;
         r_settle_cnt      <= '0;
         r_busy            <= 1'b0;
         r_done            <= 1'b0;
         r_pass            <= 1'b0;
         r_cfg_err         <= 1'b0;
         r_sample_count    <= '0;
         r_err_count       <= '0;
         r_first_err_valid <= 1'b0;
         r_first_err_vec   <= '0;
      end else if (w_accept) begin
         // The current synchronized inputs count as the first vector; no change is needed.
         r_gate_sel_q      <= gate_sel;
         r_num_q           <= num_samples;
         r_prev_ab         <= w_ab;
         r_settle_cnt      <= '0;
         r_busy            <= 1'b1;
         r_done            <= 1'b0;
         r_pass            <= 1'b0;
         r_cfg_err         <= w_cfg_bad;
         r_sample_count    <= '0;
         r_err_count       <= '0;
         r_first_err_valid <= 1'b0;
         r_first_err_vec   <= '0;
      end else begin
         case (r_state)
            S_SETTLE: begin
               if (w_chg) begin
                  r_prev_ab    <= w_ab;
                  r_settle_cnt <= '0;
               end else if (r_settle_cnt != SETTLE_LAST) begin
                  r_settle_cnt <= r_settle_cnt + 4'd1;
               end
            end
            S_COMPARE: begin
               r_sample_count <= w_sample_next;
               if (w_ys != w_expected) begin
                  if (r_err_count != '1) r_err_count <= r_err_count + CNT_W'(1);
                  if (!r_first_err_valid) begin
                     r_first_err_valid <= 1'b1;
                     r_first_err_vec   <= {w_as, w_bs, w_ys};
                  end
               end
            end
            S_WAIT_CHG: begin
               if (w_chg) begin
                  r_prev_ab    <= w_ab;
                  r_settle_cnt <= '0;
               end
            end
            S_DONE: begin
               r_busy <= 1'b0;
               r_done <= 1'b1;
               r_pass <= (r_err_count == '0) && !r_cfg_err;
            end
            default: ;
         endcase
      end
   end

   assign busy            = r_busy;
   assign done            = r_done;
   assign pass            = r_pass;
   assign cfg_err         = r_cfg_err;
   assign sample_count    = r_sample_count;
   assign err_count       = r_err_count;
   assign first_err_valid = r_first_err_valid;
   assign first_err_vec   = r_first_err_vec;
   assign dbg_state       = r_state;

endmodule

// File: tb/tb_gate_response_checker.sv
// Directed bench for gate_response_checker: expected run results are queued at start
// and popped/compared when done is observed.
module tb_gate_response_checker;

   localparam int CNT_W = 16;
   localparam int EW    = 2 * CNT_W + 6;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             start = 1'b0;
   logic [2:0]       gate_sel = 3'd0;
   logic [CNT_W-1:0] num_samples = '0;
   logic             a = 1'b0, b = 1'b0, y = 1'b0;
   logic             busy, done, pass, cfg_err, first_err_valid;
   logic [CNT_W-1:0] sample_count, err_count;
   logic [2:0]       first_err_vec, dbg_state;

   logic [EW-1:0]    exp_q[$];
   int               n_checks = 0;
   int               n_errors = 0;

   gate_response_checker #(.CNT_W(CNT_W), .SETTLE(2), .SYNC_STAGES(2)) dut (
      .clk(clk), .rst(rst), .start(start), .gate_sel(gate_sel), .num_samples(num_samples),
      .a(a), .b(b), .y(y), .busy(busy), .done(done), .pass(pass), .cfg_err(cfg_err),
      .sample_count(sample_count), .err_count(err_count), .first_err_valid(first_err_valid),
      .first_err_vec(first_err_vec), .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: observed no finish, expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_checks++;
      assert (obs === expv) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic set_in(input logic ia, input logic ib, input logic iy);
      a = ia; b = ib; y = iy;
   endtask

   task automatic pulse_start(input logic [2:0] sel, input logic [CNT_W-1:0] num);
      gate_sel = sel; num_samples = num; start = 1'b1;
      cyc(1);
      start = 1'b0;
   endtask

   function automatic logic [EW-1:0] pack(input int sc, input int ec, input logic p,
                                          input logic fev, input logic [2:0] fvec, input logic ce);
      return {CNT_W'(sc), CNT_W'(ec), p, fev, fvec, ce};
   endfunction

   task automatic wait_done(input string tag);
      int k = 0;
      while (!done && k < 200) begin
         cyc(1);
         k++;
      end
      check({tag, "_done"}, done, 1);
   endtask

   task automatic compare_result(input string tag);
      logic [EW-1:0] e;
      if (exp_q.size() == 0) begin
         check({tag, "_sb_empty"}, 1, 0);
      end else begin
         e = exp_q.pop_front();
         check({tag, "_sample_count"}, sample_count, e[EW-1 -: CNT_W]);
         check({tag, "_err_count"}, err_count, e[CNT_W+5 -: CNT_W]);
         check({tag, "_pass"}, pass, e[5]);
         check({tag, "_first_err_valid"}, first_err_valid, e[4]);
         check({tag, "_first_err_vec"}, first_err_vec, e[3:1]);
         check({tag, "_cfg_err"}, cfg_err, e[0]);
         check({tag, "_busy"}, busy, 0);
      end
   endtask

   initial begin
      // Reset state
      cyc(2);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_pass", pass, 0);
      check("rst_counts", {sample_count, err_count}, 0);
      check("rst_first_err", {first_err_valid, first_err_vec}, 0);
      rst = 1'b0;
      cyc(4);

      // XOR, correct y; a second start mid-run must be ignored
      exp_q.push_back(pack(4, 0, 1, 0, 3'b000, 0));
      pulse_start(3'd4, 16'd4);
      for (int v = 0; v < 4; v++) begin
         set_in(v[1], v[0], v[1] ^ v[0]);
         if (v == 1) begin
            cyc(2);
            pulse_start(3'd7, 16'd1);
            check("busy_ignore_start", busy, 1);
            cyc(5);
         end else begin
            cyc(8);
         end
      end
      wait_done("xor_ok");
      compare_result("xor_ok");

      // XOR, y stuck at 0
      set_in(0, 0, 0);
      cyc(4);
      exp_q.push_back(pack(4, 2, 0, 1, 3'b010, 0));
      pulse_start(3'd4, 16'd4);
      for (int v = 0; v < 4; v++) begin
         set_in(v[1], v[0], 1'b0);
         cyc(8);
      end
      wait_done("xor_stuck");
      compare_result("xor_stuck");

      // Start in DONE with invalid gate_sel: results clear immediately
      exp_q.push_back(pack(0, 0, 0, 0, 3'b000, 1));
      pulse_start(3'd7, 16'd9);
      check("restart_cleared_err", err_count, 0);
      check("restart_cleared_fev", first_err_valid, 0);
      check("restart_busy", busy, 1);
      check("restart_done_low", done, 0);
      wait_done("cfg_err");
      compare_result("cfg_err");

      // num_samples = 0
      exp_q.push_back(pack(0, 0, 1, 0, 3'b000, 0));
      pulse_start(3'd4, 16'd0);
      wait_done("zero_samples");
      compare_result("zero_samples");

      // AND with toggling inputs: nothing compared until they hold still
      gate_sel = 3'd0; num_samples = 16'd1;
      for (int i = 0; i < 10; i++) begin
         if (i % 2 == 1) set_in(1, 0, 0);
         else            set_in(0, 1, 0);
         start = (i == 3);
         cyc(1);
      end
      start = 1'b0;
      check("toggle_no_compare", sample_count, 0);
      check("toggle_busy", busy, 1);
      exp_q.push_back(pack(1, 0, 1, 0, 3'b000, 0));
      set_in(1, 1, 1);
      wait_done("and_settle");
      compare_result("and_settle");

      // Reset during SETTLE after two vectors
      set_in(0, 0, 0);
      cyc(4);
      pulse_start(3'd4, 16'd4);
      set_in(0, 0, 0);
      cyc(8);
      set_in(0, 1, 1);
      cyc(8);
      set_in(1, 0, 1);
      cyc(3);
      check("pre_rst_samples", sample_count, 2);
      check("pre_rst_state", dbg_state, 3'd1);
      #3 rst = 1'b1;
      #1;
      check("async_rst_busy", busy, 0);
      check("async_rst_counts", {sample_count, err_count}, 0);
      check("async_rst_flags", {done, pass, cfg_err, first_err_valid, first_err_vec}, 0);
      check("async_rst_state", dbg_state, 3'd0);
      cyc(1);
      rst = 1'b0;
      set_in(1, 1, 0);
      cyc(4);
      exp_q.push_back(pack(2, 0, 1, 0, 3'b000, 0));
      pulse_start(3'd4, 16'd2);
      cyc(8);
      set_in(0, 0, 0);
      cyc(8);
      wait_done("after_rst");
      compare_result("after_rst");
      check("sb_drained", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
